weight_bram_loader: RTL

WEIGHT_BRAM_LOADER -- requirements
Module: weight_bram_loader

---
 rtl/weight_bram_loader_if.sv | 26 ++
 rtl/weight_bram_loader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/weight_bram_loader_if.sv
// Upstream weight stream plus dual-port BRAM write bus for weight_bram_loader.
// slave = the loader; master = the surrounding stream source / BRAM side.
interface weight_bram_loader_if #(
  parameter int unsigned BIT_DEPTH = 16,
  parameter int unsigned ADDR_W    = 5
);
  logic                 s_valid;
  logic [BIT_DEPTH-1:0] s_data;
  logic                 s_ready;
  logic                 wren_a;
  logic                 wren_b;
  logic [ADDR_W-1:0]    address_a;
  logic [ADDR_W-1:0]    address_b;
  logic [BIT_DEPTH-1:0] data_a;
  logic [BIT_DEPTH-1:0] data_b;

  modport master (
    output s_valid, s_data,
    input  s_ready, wren_a, wren_b, address_a, address_b, data_a, data_b
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, wren_a, wren_b, address_a, address_b, data_a, data_b
  );
endinterface

// File: rtl/weight_bram_loader.sv
// Streams NUM_W weight words into a dual-port BRAM, pairing consecutive words
// into one dual write; an odd trailing word goes out alone on port A.
module weight_bram_loader #(
  parameter int unsigned BIT_DEPTH = 16,
  parameter int unsigned NUM_W     = 27,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                start,
  weight_bram_loader_if.slave bus,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CNT_W = $clog2(NUM_W + 1);

  // The all-ones address is reserved as the park address, so it can never hold a weight.
  if (NUM_W < 1 || NUM_W > (1 << ADDR_W) - 1) begin : g_param_check
    $error("weight_bram_loader: NUM_W must be in 1..2**ADDR_W-1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e               state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [BIT_DEPTH-1:0] hold_q,   hold_d;
  logic                 s_ready_q, s_ready_d;
  logic                 wren_a_q, wren_a_d;
  logic                 wren_b_q, wren_b_d;
  logic [ADDR_W-1:0]    addr_a_q, addr_a_d;
  logic [ADDR_W-1:0]    addr_b_q, addr_b_d;
  logic [BIT_DEPTH-1:0] data_a_q, data_a_d;
  logic [BIT_DEPTH-1:0] data_b_q, data_b_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic                 accept;
  logic                 last;

  // State and output registers
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      s_ready_q <= 1'b0;
      wren_a_q  <= 1'b0;
      wren_b_q  <= 1'b0;
      addr_a_q  <= '1;
      addr_b_q  <= '1;
      data_a_q  <= '0;
      data_b_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      s_ready_q <= s_ready_d;
      wren_a_q  <= wren_a_d;
      wren_b_q  <= wren_b_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    wren_a_d = 1'b0;
    wren_b_d = 1'b0;
    addr_a_d = '1;
    addr_b_d = '1;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    accept   = 1'b0;
    last     = (cnt_q == CNT_W'(NUM_W - 1));

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        accept = s_ready_q && bus.s_valid;
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q[0]) begin
            // Second word of a pair: write both words at their own addresses.
            wren_a_d = 1'b1;
            wren_b_d = 1'b1;
            addr_a_d = ADDR_W'(cnt_q) - ADDR_W'(1);
            addr_b_d = ADDR_W'(cnt_q);
            data_a_d = hold_q;
            data_b_d = bus.s_data;
          end else begin
            hold_d = bus.s_data;
            if (last) begin
              wren_a_d = 1'b1;
              addr_a_d = ADDR_W'(cnt_q);
              data_a_d = bus.s_data;
            end
          end
          if (last) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    s_ready_d = (state_d == S_LOAD);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.wren_a    = wren_a_q;
  assign bus.wren_b    = wren_b_q;
  assign bus.address_a = addr_a_q;
  assign bus.address_b = addr_b_q;
  assign bus.data_a    = data_a_q;
  assign bus.data_b    = data_b_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
